// File: rtl/traffic_control_param.sv
// N-approach intersection controller: strobe-timed green/yellow/all-red rotation with demand skipping.
// Optional emergency preempt is compiled in when EMERG_PREEMPT_EN is defined.
module traffic_control_param #(
    parameter int NUM_DIRS     = 4,
    parameter int DIR_W        = 2,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  tick_en,
    input  logic [NUM_DIRS-1:0]   req,
`ifdef EMERG_PREEMPT_EN
    input  logic                  preempt,
    input  logic [DIR_W-1:0]      preempt_dir,
`endif
    output logic [3*NUM_DIRS-1:0] lights,
    output logic [DIR_W-1:0]      green_dir,
    output logic [1:0]            phase,
    output logic                  green_start
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    if (NUM_DIRS < 2 || GREEN_TICKS == 0 || YELLOW_TICKS == 0 || DIR_W < $clog2(NUM_DIRS)) begin : g_bad_params
        $fatal(1, "traffic_control_param: illegal parameter combination");
    end

    // Durations compare against DUR-1 so a full 2**CNT_W-tick phase still fits the counter.
    localparam int                 A_DUR  = (ALLRED_TICKS == 0) ? 1 : ALLRED_TICKS;
    localparam logic [CNT_W-1:0]   G_LAST = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0]   Y_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0]   A_LAST = CNT_W'(A_DUR - 1);

    phase_t           phase_q, phase_nxt;
    logic [DIR_W-1:0] dir_q, dir_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             start_q;
    logic             enter_green;
    logic             pre_ok;
    logic [DIR_W-1:0] pre_dir;

`ifdef EMERG_PREEMPT_EN
    assign pre_ok  = preempt && (int'(preempt_dir) < NUM_DIRS);
    assign pre_dir = preempt_dir;
`else
    assign pre_ok  = 1'b0;
    assign pre_dir = '0;
`endif

    // First requesting approach after cur, wrapping round to cur itself; plain rotation if none.
    function automatic logic [DIR_W-1:0] pick_next(input logic [DIR_W-1:0] cur,
                                                   input logic [NUM_DIRS-1:0] r);
        logic [DIR_W-1:0] res;
        int               idx;
        res = (int'(cur) == NUM_DIRS - 1) ? '0 : cur + DIR_W'(1);
        for (int k = NUM_DIRS; k >= 1; k--) begin
            idx = (int'(cur) + k) % NUM_DIRS;
            if (r[idx]) res = DIR_W'(idx);
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        phase_nxt   = phase_q;
        dir_nxt     = dir_q;
        count_nxt   = count_q;
        enter_green = 1'b0;

        unique case (phase_q)
            PH_GREEN: if (tick_en) begin
                if (count_q == G_LAST) begin
                    phase_nxt = PH_YELLOW;
                    count_nxt = '0;
                end else begin
                    count_nxt = count_q + CNT_W'(1);
                end
            end
            PH_YELLOW: if (tick_en) begin
                if (count_q == Y_LAST) begin
                    if (ALLRED_TICKS == 0) begin
                        enter_green = 1'b1;
                    end else begin
                        phase_nxt = PH_ALLRED;
                        count_nxt = '0;
                    end
                end else begin
                    count_nxt = count_q + CNT_W'(1);
                end
            end
            PH_ALLRED: if (tick_en) begin
                if (count_q == A_LAST) enter_green = 1'b1;
                else                   count_nxt = count_q + CNT_W'(1);
            end
            default: begin
                phase_nxt = PH_GREEN;
                count_nxt = '0;
            end
        endcase

        // Preempt during green either yields at once or pins the served approach's timer at zero.
        if (pre_ok && phase_q == PH_GREEN) begin
            phase_nxt = (dir_q != pre_dir) ? PH_YELLOW : PH_GREEN;
            count_nxt = '0;
        end

        if (enter_green) begin
            phase_nxt = PH_GREEN;
            count_nxt = '0;
            dir_nxt   = pre_ok ? pre_dir : pick_next(dir_q, req);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_a) begin
            phase_q <= PH_GREEN;
            dir_q   <= '0;
            count_q <= '0;
            start_q <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            dir_q   <= dir_nxt;
            count_q <= count_nxt;
            start_q <= enter_green;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIRS; i++) begin
            lights[3*i +: 3] = 3'b100;
            if (int'(dir_q) == i && phase_q == PH_GREEN)  lights[3*i +: 3] = 3'b001;
            if (int'(dir_q) == i && phase_q == PH_YELLOW) lights[3*i +: 3] = 3'b010;
        end
    end

    assign phase       = phase_q;
    assign green_dir   = dir_q;
    assign green_start = start_q;

endmodule

// File: tb/tb_traffic_control_param.sv
// Directed bench for traffic_control_param: default build, no-all-red build, and a small 3-way build
// with a full-range counter. Preempt scenarios run when EMERG_PREEMPT_EN is defined.
module tb_traffic_control_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default instance
    logic        rst_a = 1'b1, tick_en = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic [11:0] lights;
    logic [1:0]  green_dir, phase;
    logic        green_start;
    logic        pre_a = 1'b0;
    logic [1:0]  pdir_a = 2'd0;

    // ALLRED_TICKS = 0 instance
    logic        rst_b = 1'b1, tick_b = 1'b1;
    logic [3:0]  req_b = 4'b1111;
    logic [11:0] lights_b;
    logic [1:0]  gd_b, ph_b;
    logic        gs_b;
    logic        pre_b = 1'b0;
    logic [1:0]  pdir_b = 2'd0;

    // 3 approaches, 2-bit counter, GREEN_TICKS = 2**CNT_W
    logic        rst_c = 1'b1, tick_c = 1'b1;
    logic [2:0]  req_c = 3'b000;
    logic [8:0]  lights_c;
    logic [1:0]  gd_c, ph_c;
    logic        gs_c;
    logic        pre_c = 1'b0;
    logic [1:0]  pdir_c = 2'd0;

    traffic_control_param u_dut (
        .clk(clk), .rst_a(rst_a), .tick_en(tick_en), .req(req),
`ifdef EMERG_PREEMPT_EN
        .preempt(pre_a), .preempt_dir(pdir_a),
`endif
        .lights(lights), .green_dir(green_dir), .phase(phase), .green_start(green_start)
    );

    traffic_control_param #(.ALLRED_TICKS(0)) u_nr (
        .clk(clk), .rst_a(rst_b), .tick_en(tick_b), .req(req_b),
`ifdef EMERG_PREEMPT_EN
        .preempt(pre_b), .preempt_dir(pdir_b),
`endif
        .lights(lights_b), .green_dir(gd_b), .phase(ph_b), .green_start(gs_b)
    );

    traffic_control_param #(.NUM_DIRS(3), .DIR_W(2), .CNT_W(2), .GREEN_TICKS(4),
                            .YELLOW_TICKS(1), .ALLRED_TICKS(1)) u_sm (
        .clk(clk), .rst_a(rst_c), .tick_en(tick_c), .req(req_c),
`ifdef EMERG_PREEMPT_EN
        .preempt(pre_c), .preempt_dir(pdir_c),
`endif
        .lights(lights_c), .green_dir(gd_c), .phase(ph_c), .green_start(gs_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
    endtask

    initial begin
        int n_ar;
        #1;

        // T1: full rotation, req all set
        reset_a();
        check("rst_phase", phase, 2'b00);
        check("rst_dir", green_dir, 2'd0);
        check("rst_lights", lights, 12'b100_100_100_001);
        check("rst_gstart", green_start, 1'b0);
        step(7);  check("t1_green_end", phase, 2'b00);
        step(1);  check("t1_yellow", phase, 2'b01);
                  check("t1_y_lights", lights, 12'b100_100_100_010);
        step(3);  check("t1_yellow_end", phase, 2'b01);
        step(1);  check("t1_allred", phase, 2'b10);
                  check("t1_ar_lights", lights, 12'b100_100_100_100);
        step(1);  check("t1_allred_end", phase, 2'b10);
        step(1);  check("t1_dir1", green_dir, 2'd1);
                  check("t1_gs_hi", green_start, 1'b1);
                  check("t1_g1_lights", lights, 12'b100_100_001_100);
        step(1);  check("t1_gs_lo", green_start, 1'b0);
        step(13); check("t1_dir2", green_dir, 2'd2);
        step(14); check("t1_dir3", green_dir, 2'd3);
        step(14); check("t1_dir0", green_dir, 2'd0);
                  check("t1_loop_gs", green_start, 1'b1);

        // T2: reset mid-yellow on approach 2 (t=56 -> t=93)
        step(37); check("t2_pre_phase", phase, 2'b01);
                  check("t2_pre_dir", green_dir, 2'd2);
        reset_a();
        check("t2_phase", phase, 2'b00);
        check("t2_dir", green_dir, 2'd0);
        check("t2_lights", lights, 12'b100_100_100_001);

        // T3: demand skip, wrap rotation, re-serve same approach
        req = 4'b1000;
        step(14); check("t3_skip_to3", green_dir, 2'd3);
        req = 4'b0000;
        step(14); check("t3_wrap_to0", green_dir, 2'd0);
        req = 4'b0001;
        step(13); check("t3_self_ar", phase, 2'b10);
        step(1);  check("t3_self_dir", green_dir, 2'd0);
                  check("t3_self_gs", green_start, 1'b1);

        // T4: tick gating, 1 tick in 3, then freeze mid-yellow with count at 2
        req = 4'b1111;
        reset_a();
        for (int i = 0; i < 28; i++) begin
            tick_en = (i % 3 == 0);
            step(1);
            if (i == 20) check("t4_green_hold", phase, 2'b00);
            if (i == 21) check("t4_yellow", phase, 2'b01);
        end
        tick_en = 1'b0;
        step(30); check("t4_frozen", phase, 2'b01);
        tick_en = 1'b1;
        step(1);  check("t4_resume_y", phase, 2'b01);
        step(1);  check("t4_resume_ar", phase, 2'b10);

        // T5: no all-red build, 48-cycle loop
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        n_ar = 0;
        for (int t = 1; t <= 48; t++) begin
            step(1);
            if (ph_b == 2'b10) n_ar++;
            if (t == 8)  check("t5_yellow", ph_b, 2'b01);
            if (t == 12) check("t5_dir1", {ph_b, gd_b}, {2'b00, 2'd1});
            if (t == 24) check("t5_dir2", gd_b, 2'd2);
            if (t == 36) check("t5_dir3", gd_b, 2'd3);
            if (t == 48) check("t5_dir0", {gs_b, gd_b}, {1'b1, 2'd0});
        end
        check("t5_no_allred", n_ar, 0);

        // T7: 3 approaches, full-range green, wrap 2->0 (invalid preempt_dir rides along when enabled)
`ifdef EMERG_PREEMPT_EN
        pre_c  = 1'b1;
        pdir_c = 2'd3;
`endif
        rst_c = 1'b1;
        step(1);
        rst_c = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            step(1);
            if (t == 3)  check("t7_green_end", {ph_c, gd_c}, {2'b00, 2'd0});
            if (t == 4)  check("t7_y_lights", lights_c, 9'b100_100_010);
            if (t == 5)  check("t7_allred", ph_c, 2'b10);
            if (t == 6)  check("t7_g1_lights", lights_c, 9'b100_001_100);
            if (t == 12) check("t7_dir2", gd_c, 2'd2);
            if (t == 18) check("t7_wrap0", {gs_c, gd_c}, {1'b1, 2'd0});
        end

`ifdef EMERG_PREEMPT_EN
        // T6: preempt to approach 2 from green on 0 at count 3
        tick_en = 1'b1;
        req = 4'b1111;
        reset_a();
        step(3);
        pre_a  = 1'b1;
        pdir_a = 2'd2;
        step(1);  check("t6_yellow_now", {phase, green_dir}, {2'b01, 2'd0});
        step(3);  check("t6_yellow_end", phase, 2'b01);
        step(1);  check("t6_allred", phase, 2'b10);
        step(1);  check("t6_allred_end", phase, 2'b10);
        step(1);  check("t6_green2", {phase, green_dir}, {2'b00, 2'd2});
        step(20); check("t6_held", {phase, green_dir}, {2'b00, 2'd2});
        pre_a = 1'b0;
        step(7);  check("t6_release_g", phase, 2'b00);
        step(1);  check("t6_release_y", phase, 2'b01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
